// File: rtl/retire_unit_pkg.sv
// Shared widths, entry layout and MSB-lane-first bus slicing helpers
// for the retirement buffer and the register file.
package retire_unit_pkg;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 5;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Lane 0 lives in the most-significant slice.
  function automatic tag_t tag_lane(
    input logic [LANES*TAG_W-1:0] f,
    input int k
  );
    return f[TAG_W*(LANES-1-k) +: TAG_W];
  endfunction

  function automatic reg_t reg_lane(
    input logic [LANES*REG_W-1:0] f,
    input int k
  );
    return f[REG_W*(LANES-1-k) +: REG_W];
  endfunction

  function automatic data_t data_lane(
    input logic [LANES*DATA_W-1:0] f,
    input int k
  );
    return f[DATA_W*(LANES-1-k) +: DATA_W];
  endfunction
endpackage

// File: rtl/retire_unit_select.sv
// Counts the run of valid+done entries from head (at most LANES)
// and produces the wrapped indices of the retire lanes.
module retire_select
  import retire_unit_pkg::*;
(
  input  logic [TAG_W-1:0]            head,
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0]            done,
  output logic [2:0]                  count,
  output logic [LANES-1:0][TAG_W-1:0] idx
);
  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    idx   = '0;
    for (int i = 0; i < LANES; i++) begin
      idx[i] = head + tag_t'(i);
      if (run && valid[idx[i]] && done[idx[i]])
        count = count + 3'd1;
      else
        run = 1'b0;
    end
  end
endmodule

// File: rtl/retire_unit.sv
// In-order reorder buffer: tag allocation, CDB capture and up to
// four in-order retirements per cycle onto a registered write bundle.
module retire_unit
  import retire_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [LANES-1:0]        dispatch_valid_flat,
  input  logic [LANES-1:0]        dispatch_has_dest_flat,
  input  logic [LANES*REG_W-1:0]  dispatch_target_reg_flat,
  output logic                    dispatch_ready,
  output logic [LANES*TAG_W-1:0]  alloc_tag_flat,
  input  logic [LANES-1:0]        cdb_valid_flat,
  input  logic [LANES*TAG_W-1:0]  cdb_tag_flat,
  input  logic [LANES*DATA_W-1:0] cdb_value_flat,
  output logic [LANES-1:0]        retirement_write_data_enable_flat,
  output logic [LANES*REG_W-1:0]  retirement_target_reg_flat,
  output logic [LANES*DATA_W-1:0] retirement_write_data_flat,
  output logic [LANES*TAG_W-1:0]  instruction_writer_flat,
  output logic [2:0]              retire_count,
  output logic                    empty,
  output logic                    full
);
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] has_dest_q;
  reg_t             target_q [DEPTH];
  data_t            value_q  [DEPTH];
  tag_t             head_q;
  tag_t             tail_q;
  cnt_t             count_q;

  logic [2:0]                  ret_k;
  logic [LANES-1:0][TAG_W-1:0] ret_idx;
  tag_t [LANES-1:0]            lane_tag;
  logic [2:0]                  disp_n;
  logic [2:0]                  disp_acc;

  logic [LANES-1:0]        ret_en;
  logic [LANES*REG_W-1:0]  ret_tgt;
  logic [LANES*DATA_W-1:0] ret_data;
  logic [LANES*TAG_W-1:0]  ret_wr;

  retire_select u_select (
    .head  (head_q),
    .valid (valid_q),
    .done  (done_q),
    .count (ret_k),
    .idx   (ret_idx)
  );

  assign dispatch_ready = count_q <= cnt_t'(DEPTH - LANES);
  assign empty          = count_q == '0;
  assign full           = count_q == cnt_t'(DEPTH);

  always_comb begin
    disp_n         = '0;
    lane_tag       = '0;
    alloc_tag_flat = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_tag[k] = tail_q + tag_t'(disp_n);
      alloc_tag_flat[TAG_W*(LANES-1-k) +: TAG_W] = lane_tag[k];
      if (dispatch_valid_flat[LANES-1-k])
        disp_n = disp_n + 3'd1;
    end
    disp_acc = dispatch_ready ? disp_n : 3'd0;
  end

  always_comb begin
    ret_en   = '0;
    ret_tgt  = '0;
    ret_data = '0;
    ret_wr   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) < ret_k) begin
        ret_en[LANES-1-i] = has_dest_q[ret_idx[i]];
        ret_tgt[REG_W*(LANES-1-i) +: REG_W] =
          target_q[ret_idx[i]];
        ret_data[DATA_W*(LANES-1-i) +: DATA_W] =
          value_q[ret_idx[i]];
        ret_wr[TAG_W*(LANES-1-i) +: TAG_W] = ret_idx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      retire_count <= '0;
      retirement_write_data_enable_flat <= '0;
      retirement_target_reg_flat        <= '0;
      retirement_write_data_flat        <= '0;
      instruction_writer_flat           <= '0;
    end else begin
      // Ascending lane order: the highest duplicate lane lands last.
      for (int c = 0; c < LANES; c++) begin
        if (cdb_valid_flat[LANES-1-c] &&
            valid_q[tag_lane(cdb_tag_flat, c)]) begin
          done_q[tag_lane(cdb_tag_flat, c)]  <= 1'b1;
          value_q[tag_lane(cdb_tag_flat, c)] <=
            data_lane(cdb_value_flat, c);
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (3'(i) < ret_k) begin
          valid_q[ret_idx[i]] <= 1'b0;
          done_q[ret_idx[i]]  <= 1'b0;
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (dispatch_ready && dispatch_valid_flat[LANES-1-k]) begin
          valid_q[lane_tag[k]]    <= 1'b1;
          done_q[lane_tag[k]]     <= 1'b0;
          has_dest_q[lane_tag[k]] <=
            dispatch_has_dest_flat[LANES-1-k];
          target_q[lane_tag[k]]   <=
            reg_lane(dispatch_target_reg_flat, k);
        end
      end
      head_q       <= head_q + tag_t'(ret_k);
      tail_q       <= tail_q + tag_t'(disp_acc);
      count_q      <= count_q + cnt_t'(disp_acc) - cnt_t'(ret_k);
      retire_count <= ret_k;
      retirement_write_data_enable_flat <= ret_en;
      retirement_target_reg_flat        <= ret_tgt;
      retirement_write_data_flat        <= ret_data;
      instruction_writer_flat           <= ret_wr;
    end
  end
endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: allocation, out-of-order completion,
// no-dest retire, backpressure, wrap, flush and reset.
module tb_retire_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  dv;
  logic [3:0]  dh;
  logic [15:0] dr;
  logic        ready;
  logic [15:0] alloc;
  logic [3:0]  cv;
  logic [15:0] ct;
  logic [63:0] cval;
  logic [3:0]  ren;
  logic [15:0] rtgt;
  logic [63:0] rdata;
  logic [15:0] rwr;
  logic [2:0]  rcnt;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  retire_unit dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .flush                             (flush),
    .dispatch_valid_flat               (dv),
    .dispatch_has_dest_flat            (dh),
    .dispatch_target_reg_flat          (dr),
    .dispatch_ready                    (ready),
    .alloc_tag_flat                    (alloc),
    .cdb_valid_flat                    (cv),
    .cdb_tag_flat                      (ct),
    .cdb_value_flat                    (cval),
    .retirement_write_data_enable_flat (ren),
    .retirement_target_reg_flat        (rtgt),
    .retirement_write_data_flat        (rdata),
    .instruction_writer_flat           (rwr),
    .retire_count                      (rcnt),
    .empty                             (empty),
    .full                              (full)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    dv = '0; dh = '0; dr = '0;
    cv = '0; ct = '0; cval = '0;
  endtask

  task automatic ret_chk(input string t, input logic [3:0] en,
                         input logic [15:0] tg, input logic [63:0] d,
                         input logic [15:0] w, input logic [2:0] n);
    chk({t, "_en"}, 64'(ren), 64'(en));
    chk({t, "_tgt"}, 64'(rtgt), 64'(tg));
    chk({t, "_data"}, rdata, d);
    chk({t, "_wr"}, 64'(rwr), 64'(w));
    chk({t, "_cnt"}, 64'(rcnt), 64'(n));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    for (int i = 0; i < 2; i++) begin
      dv = 4'($urandom); dh = 4'($urandom); dr = 16'($urandom);
      cv = 4'($urandom); ct = 16'($urandom);
      cval = {$urandom, $urandom};
      flush = 1'($urandom);
      step();
    end
    ret_chk("rst", 4'h0, 16'h0, 64'h0, 16'h0, 3'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(ready), 64'd1);
    rst_n = 1'b1;
    idle();

    // dispatch R1..R4 -> tags 0..3
    dv = 4'b1111; dh = 4'b1111; dr = 16'h1234;
    #1;
    chk("alloc0", 64'(alloc), 64'h0123);
    step();
    idle();
    chk("empty_after_disp", 64'(empty), 64'd0);

    // out-of-order completion
    cv = 4'b1000; ct = 16'h2000; cval = 64'h00AA << 48;
    step();
    idle();
    chk("ooo_cnt_a", 64'(rcnt), 64'd0);
    cv = 4'b1000; ct = 16'h0000; cval = 64'h0011 << 48;
    step();
    idle();
    chk("ooo_cnt_b", 64'(rcnt), 64'd0);
    cv = 4'b1000; ct = 16'h1000; cval = 64'h0022 << 48;
    step();
    idle();
    ret_chk("ooo1", 4'b1000, 16'h1000, 64'h0011_0000_0000_0000,
            16'h0000, 3'd1);
    step();
    ret_chk("ooo2", 4'b1100, 16'h2300, 64'h0022_00AA_0000_0000,
            16'h1200, 3'd2);
    step();
    ret_chk("pulse", 4'b0000, 16'h0, 64'h0, 16'h0, 3'd0);

    // tag 3 completes on CDB lane 3
    cv = 4'b0001; ct = 16'h0003; cval = 64'h0044;
    step();
    idle();
    step();
    ret_chk("lane3", 4'b1000, 16'h4000, 64'h0044_0000_0000_0000,
            16'h3000, 3'd1);
    chk("empty_again", 64'(empty), 64'd1);

    // lane 1 has no destination
    dv = 4'b1111; dh = 4'b1011; dr = 16'h5678;
    #1;
    chk("alloc1", 64'(alloc), 64'h4567);
    step();
    idle();
    cv = 4'b1111; ct = 16'h4567; cval = 64'h0101_0202_0303_0404;
    step();
    idle();
    step();
    ret_chk("nodest", 4'b1011, 16'h5678, 64'h0101_0202_0303_0404,
            16'h4567, 3'd4);

    // sparse dispatch lanes 1 and 3 -> tags 8, 9
    dv = 4'b0101; dh = 4'b0101; dr = 16'h0900 | 16'h000A;
    #1;
    chk("alloc_sparse", 64'(alloc & 16'h0F0F), 64'h0809);
    step();
    idle();
    // duplicate tag 8 on lanes 0 and 2; stray hit on free tag 12
    cv = 4'b1011; ct = 16'h8080 | 16'h000C;
    cval = 64'hDEAD_0000_BEEF_7777;
    step();
    idle();
    step();
    ret_chk("dup", 4'b1000, 16'h9000, 64'hBEEF_0000_0000_0000,
            16'h8000, 3'd1);
    cv = 4'b1000; ct = 16'h9000; cval = 64'h0A0A << 48;
    step();
    idle();
    step();
    ret_chk("tag9", 4'b1000, 16'hA000, 64'h0A0A_0000_0000_0000,
            16'h9000, 3'd1);

    // fill from tail=10 with no completions
    for (int n = 0; n < 4; n++) begin
      dv = 4'b1111; dh = 4'b1111;
      dr = (n == 1) ? 16'h2345 : 16'h1111 * 16'(n + 1);
      #1;
      chk($sformatf("fill_ready%0d", n), 64'(ready), 64'd1);
      step();
    end
    chk("full", 64'(full), 64'd1);
    chk("full_ready", 64'(ready), 64'd0);
    step();
    idle();
    chk("full_hold", 64'(full), 64'd1);
    cv = 4'b1111; ct = 16'hABCD; cval = 64'h1010_1111_1212_1313;
    step();
    idle();
    chk("still_full", 64'(ready), 64'd0);
    step();
    chk("drain_cnt", 64'(rcnt), 64'd4);
    chk("drain_wr", 64'(rwr), 64'hABCD);
    chk("drain_ready", 64'(ready), 64'd1);
    chk("drain_full", 64'(full), 64'd0);

    // wrap: head=14 retires 14,15,0,1 in one edge
    cv = 4'b1111; ct = 16'hEF01; cval = 64'h1E1E_1F1F_2020_2121;
    step();
    idle();
    step();
    ret_chk("wrap", 4'b1111, 16'h2345, 64'h1E1E_1F1F_2020_2121,
            16'hEF01, 3'd4);

    // flush with simultaneous CDB hit and dispatch
    flush = 1'b1;
    cv = 4'b1000; ct = 16'h2000; cval = 64'h5555 << 48;
    dv = 4'b1111; dh = 4'b1111; dr = 16'h7777;
    step();
    idle();
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_en", 64'(ren), 64'd0);
    chk("flush_cnt", 64'(rcnt), 64'd0);
    dv = 4'b1000; dh = 4'b1000; dr = 16'h3000;
    #1;
    chk("flush_alloc", 64'(alloc & 16'hF000), 64'h0000);
    step();
    idle();
    step();
    chk("flush_noret", 64'(rcnt), 64'd0);

    // reset abandons a completed entry
    cv = 4'b1000; ct = 16'h0000; cval = 64'h6666 << 48;
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ret_chk("rst_mid", 4'h0, 16'h0, 64'h0, 16'h0, 3'd0);
    chk("rst_mid_empty", 64'(empty), 64'd1);
    step();
    chk("rst_mid_after", 64'(rcnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
